// File: rtl/mux4_arbiter.sv
// mux4_arbiter: 4-way round-robin arbiter driving a 4:1 mux select.
// Owner keeps the grant while its request stays high. Release advances the
// pointer past the owner and hands over on the same edge.
// Optional feature macro ARB_TIMEOUT_EN: forced rotation after MAX_HOLD cycles
// when another requester is waiting.
module mux4_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       busy
);

   localparam int unsigned N_REQ  = 4;
   localparam int unsigned IDX_W  = 2;
   localparam int unsigned HOLD_W = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t             state, state_n;
   logic [N_REQ-1:0]   gnt_n;
   logic [IDX_W-1:0]   sel_n;
   logic               busy_n;
   logic [IDX_W-1:0]   ptr, ptr_n;
   logic [N_REQ-1:0]   owner_mask;
   logic [IDX_W:0]     scan;
   logic               release_c;
`ifdef ARB_TIMEOUT_EN
   logic [HOLD_W-1:0]  hold_cnt, hold_n;
   logic               timeout_c;
`endif

   // Reject out-of-range hold limits at elaboration time
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("mux4_arbiter: MAX_HOLD must be within 2..255");
   end

   // First asserted request at or after start, wrapping mod 4; {found, index}
   function automatic logic [IDX_W:0] rr_scan(input logic [N_REQ-1:0] r,
                                              input logic [IDX_W-1:0] start);
      logic [IDX_W-1:0] idx;
      rr_scan = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = start + IDX_W'(i);
         if (r[idx]) rr_scan = {1'b1, idx};
      end
   endfunction

   assign owner_mask = N_REQ'(4'b0001 << sel);

`ifdef ARB_TIMEOUT_EN
   // Owner has used its quota and someone else is waiting
   assign timeout_c = (hold_cnt == HOLD_W'(MAX_HOLD)) && |(req & ~owner_mask);
   assign release_c = !req[sel] || timeout_c;
`else
   assign release_c = !req[sel];
`endif

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= '0;
         sel      <= '0;
         busy     <= 1'b0;
         ptr      <= '0;
`ifdef ARB_TIMEOUT_EN
         hold_cnt <= '0;
`endif
      end else begin
         state    <= state_n;
         gnt      <= gnt_n;
         sel      <= sel_n;
         busy     <= busy_n;
         ptr      <= ptr_n;
`ifdef ARB_TIMEOUT_EN
         hold_cnt <= hold_n;
`endif
      end
   end

   // Next-state, grant selection and pointer update
   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      sel_n   = sel;
      busy_n  = busy;
      ptr_n   = ptr;
      scan    = '0;
`ifdef ARB_TIMEOUT_EN
      hold_n  = hold_cnt;
`endif
      case (state)
         IDLE: begin
            scan = rr_scan(req, ptr);
            if (scan[IDX_W]) begin
               state_n = GRANT;
               gnt_n   = N_REQ'(4'b0001 << scan[IDX_W-1:0]);
               sel_n   = scan[IDX_W-1:0];
               busy_n  = 1'b1;
`ifdef ARB_TIMEOUT_EN
               hold_n  = HOLD_W'(1);
`endif
            end else begin
               gnt_n  = '0;
               busy_n = 1'b0;
            end
         end
         GRANT: begin
            if (release_c) begin
               // Releasing owner is masked so it can never win its own release edge
               ptr_n = sel + IDX_W'(1);
               scan  = rr_scan(req & ~owner_mask, ptr_n);
               if (scan[IDX_W]) begin
                  gnt_n  = N_REQ'(4'b0001 << scan[IDX_W-1:0]);
                  sel_n  = scan[IDX_W-1:0];
                  busy_n = 1'b1;
`ifdef ARB_TIMEOUT_EN
                  hold_n = HOLD_W'(1);
`endif
               end else begin
                  state_n = IDLE;
                  gnt_n   = '0;
                  busy_n  = 1'b0;
               end
            end else begin
`ifdef ARB_TIMEOUT_EN
               if (hold_cnt != {HOLD_W{1'b1}}) hold_n = hold_cnt + HOLD_W'(1);
`endif
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Scoreboard bench for mux4_arbiter: the driver runs a behavioural model and
// queues expected outputs; a monitor pops and compares after every clock edge.
module tb_mux4_arbiter;

   localparam int unsigned TB_MAX_HOLD = 4;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;

   int errors = 0;
   int checks = 0;
   bit mon_en = 0;

   // expected {gnt, sel, busy}
   logic [6:0] sb[$];

   // behavioural model state
   int m_owner = -1;
   int m_ptr   = 0;
   int m_hold  = 0;
   int m_sel   = 0;

   mux4_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req),
      .gnt  (gnt),
      .sel  (sel),
      .busy (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // first requester in r at or after start (mod 4), skipping excl; -1 if none
   function automatic int pick(input logic [3:0] r, input int start, input int excl);
      for (int k = 0; k < 4; k++) begin
         int c = (start + k) % 4;
         if (c != excl && r[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_sel   = 0;
   endtask

   task automatic model_edge(input logic [3:0] r);
      bit rel;
      int c;
      if (m_owner < 0) begin
         c = pick(r, m_ptr, -1);
         if (c >= 0) begin
            m_owner = c;
            m_sel   = c;
            m_hold  = 1;
         end
      end else begin
         rel = !r[m_owner];
`ifdef ARB_TIMEOUT_EN
         if (m_hold == TB_MAX_HOLD && pick(r, 0, m_owner) >= 0) rel = 1;
`endif
         if (rel) begin
            m_ptr = (m_owner + 1) % 4;
            c = pick(r, m_ptr, m_owner);
            m_owner = c;
            if (c >= 0) begin
               m_sel  = c;
               m_hold = 1;
            end
         end else if (m_hold < 255) begin
            m_hold++;
         end
      end
   endtask

   function automatic logic [6:0] model_out();
      logic [3:0] g;
      g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      return {g, 2'(m_sel), (m_owner >= 0)};
   endfunction

   // drive one cycle of requests and queue the expected post-edge outputs
   task automatic step(input logic [3:0] r);
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      req = r;
      model_edge(r);
      sb.push_back(model_out());
      mon_en = 1;
      @(posedge clk);
   endtask

   // mid-cycle async reset; must be called at a posedge time
   task automatic do_reset();
      #3;
      mon_en = 0;
      rst_n  = 1'b0;
      #1;
      check("async_rst_gnt", int'(gnt), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_sel", int'(sel), 0);
      model_reset();
      sb.delete();
   endtask

   // compare DUT outputs with the queued expectation after each edge
   always @(posedge clk) begin
      logic [6:0] e;
      #1;
      if (mon_en) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: got output %0h with no expectation queued", {gnt, sel, busy});
         end else begin
            e = sb.pop_front();
            if ({gnt, sel, busy} !== e) begin
               errors++;
               $display("FAIL sb_cycle: got gnt=%b sel=%0d busy=%b expected gnt=%b sel=%0d busy=%b",
                        gnt, sel, busy, e[6:3], e[2:1], e[0]);
            end
         end
      end
   end

   initial begin
      logic [3:0] r;
      rst_n = 1'b0;
      req   = 4'b1111;
      model_reset();

      // reset with all requests high
      #12;
      check("rst_gnt", int'(gnt), 0);
      check("rst_sel", int'(sel), 0);
      check("rst_busy", int'(busy), 0);
      step(4'b1111);
      #2 check("first_grant", int'(gnt), 4'b0001);

      // single request and release, sel holds
      do_reset();
      step(4'b0100);
      #2 check("single_gnt", int'(gnt), 4'b0100);
      check("single_sel", int'(sel), 2);
      check("single_busy", int'(busy), 1);
      step(4'b0000);
      #2 check("drop_gnt", int'(gnt), 0);
      check("drop_busy", int'(busy), 0);
      check("drop_sel", int'(sel), 2);

      // pointer fairness: owner 2 releases, 0 wins over 1
      step(4'b0100);
      step(4'b0011);
      #2 check("fair_sel", int'(sel), 0);

      // rotation with no idle bubble
      do_reset();
      step(4'b1111);
      for (int k = 0; k < 4; k++) begin
         step(4'b1111);
         step(4'b1111 & ~4'(1 << k));
         #2 check("rot_sel", int'(sel), (k + 1) % 4);
         check("rot_busy", int'(busy), 1);
      end

      // constant contention between 0 and 1
      do_reset();
      for (int k = 0; k < 6; k++) step(4'b0011);
`ifdef ARB_TIMEOUT_EN
      #2 check("timeout_gnt", int'(gnt), 4'b0010);
`else
      #2 check("timeout_gnt", int'(gnt), 4'b0001);
`endif
      for (int k = 0; k < 6; k++) step(4'b0011);

      // async reset while requester 3 owns, then restart from 0
      do_reset();
      step(4'b1000);
      #2 check("own3_gnt", int'(gnt), 4'b1000);
      do_reset();
      step(4'b1111);
      #2 check("post_rst_gnt", int'(gnt), 4'b0001);

      // randomized traffic with sticky owners and occasional resets
      for (int n = 0; n < 400; n++) begin
         r = 4'($urandom_range(0, 15));
         if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
         step(r);
         if ($urandom_range(0, 59) == 0) do_reset();
      end

      #3;
      mon_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
